// File: rtl/fft_addr_gen_if.sv
// rtl/fft_addr_gen_if.sv - control and read-address bundle of the FFT address sequencer
interface fft_addr_gen_if #(
  parameter int ADDR_SIZE = 5,
  parameter int STAGE_W   = 3
);
  logic                 i_start;
  logic                 i_stall;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_rd_valid;
  logic [ADDR_SIZE-1:0] o_rdaddr_A;
  logic [ADDR_SIZE-1:0] o_rdaddr_B;
  logic [ADDR_SIZE-2:0] o_twiddle_idx;
  logic [STAGE_W-1:0]   o_stage;

  // Controller side: requests transforms and throttles issue.
  modport master (
    output i_start, i_stall,
    input  o_busy, o_done, o_rd_valid, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx, o_stage
  );

  // Sequencer side.
  modport slave (
    input  i_start, i_stall,
    output o_busy, o_done, o_rd_valid, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx, o_stage
  );
endinterface

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - radix-2 DIT butterfly read-address and twiddle sequencer
module fft_addr_gen #(
  parameter int ADDR_SIZE    = 5,
  parameter int STAGE_W      = 3,
  parameter int PIPE_LATENCY = 2
) (
  input  logic           i_CLK,
  input  logic           i_RST,
  fft_addr_gen_if.slave  bus
);

  localparam int K_W = ADDR_SIZE - 1;
  localparam int D_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [K_W-1:0]     K_LAST = {K_W{1'b1}};
  localparam logic [D_W-1:0]     D_LAST = (PIPE_LATENCY > 0) ? D_W'(PIPE_LATENCY - 1) : '0;
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(ADDR_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [K_W-1:0]     r_k;
  logic [K_W-1:0]     w_k_nxt;
  logic [STAGE_W-1:0] r_stage;
  logic [STAGE_W-1:0] w_stage_nxt;
  logic [D_W-1:0]     r_d;
  logic [D_W-1:0]     w_d_nxt;

  // Address decode: split k at bit s and open a zero gap there for the top leg.
  logic [ADDR_SIZE-1:0] w_span;
  logic [ADDR_SIZE-1:0] w_mask;
  logic [ADDR_SIZE-1:0] w_kx;
  logic [ADDR_SIZE-1:0] w_lo;
  logic [ADDR_SIZE-1:0] w_addr_a;
  logic [ADDR_SIZE-1:0] w_addr_b;
  logic [STAGE_W-1:0]   w_tw_shift;
  logic [K_W-1:0]       w_twiddle;

  assign w_span     = ADDR_SIZE'(1) << r_stage;
  assign w_mask     = w_span - 1'b1;
  assign w_kx       = {1'b0, r_k};
  assign w_lo       = w_kx & w_mask;
  assign w_addr_a   = ((w_kx & ~w_mask) << 1) | w_lo;
  assign w_addr_b   = w_addr_a | w_span;
  assign w_tw_shift = S_LAST - r_stage;
  assign w_twiddle  = K_W'(w_lo << w_tw_shift);

  // State and counter registers; reset aborts any transform without a done pulse.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      r_d     <= w_d_nxt;
    end
  end

  // Next-state and counter update: k walks one stage, then drain, then next stage.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_d_nxt     = r_d;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = S_ISSUE;
          w_k_nxt     = '0;
          w_stage_nxt = '0;
        end
      end
      S_ISSUE: begin
        if (!bus.i_stall) begin
          w_k_nxt = r_k + 1'b1;
          if (r_k == K_LAST) begin
            w_k_nxt = '0;
            if (PIPE_LATENCY == 0) begin
              if (r_stage == S_LAST) begin
                w_state_nxt = S_DONE;
              end else begin
                w_stage_nxt = r_stage + 1'b1;
                w_state_nxt = S_ISSUE;
              end
            end else begin
              w_d_nxt     = '0;
              w_state_nxt = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        w_d_nxt = r_d + 1'b1;
        if (r_d == D_LAST) begin
          if (r_stage == S_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_stage_nxt = r_stage + 1'b1;
            w_k_nxt     = '0;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
        w_stage_nxt = '0;
        w_d_nxt     = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state; stall gates only the valid flag.
  always_comb begin
    bus.o_busy        = 1'b0;
    bus.o_done        = 1'b0;
    bus.o_rd_valid    = 1'b0;
    bus.o_rdaddr_A    = '0;
    bus.o_rdaddr_B    = '0;
    bus.o_twiddle_idx = '0;
    bus.o_stage       = '0;
    if (r_state != S_IDLE) begin
      bus.o_busy        = 1'b1;
      bus.o_rdaddr_A    = w_addr_a;
      bus.o_rdaddr_B    = w_addr_b;
      bus.o_twiddle_idx = w_twiddle;
      bus.o_stage       = r_stage;
    end
    if (r_state == S_ISSUE) begin
      bus.o_rd_valid = !bus.i_stall;
    end
    if (r_state == S_DONE) begin
      bus.o_done = 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb/tb_fft_addr_gen.sv - scoreboard bench for the FFT address sequencer
module tb_fft_addr_gen;
  localparam int ASZ  = 5;
  localparam int SW   = 3;
  localparam int PL   = 2;
  localparam int N    = 1 << ASZ;
  localparam int HALF = N / 2;

  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_addr_gen_if #(.ADDR_SIZE(ASZ), .STAGE_W(SW)) bus ();

  fft_addr_gen #(.ADDR_SIZE(ASZ), .STAGE_W(SW), .PIPE_LATENCY(PL)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  typedef struct {
    int s;
    int k;
    int a;
    int b;
    int tw;
  } pair_t;

  pair_t sb[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int m_phase, m_s, m_k, m_d, m_dones, m_start_cyc, m_done_cyc, cyc, stalls_done;
  bit e_busy, e_done, e_valid, e_idle, e_held;
  int e_ha, e_hb;

  // monitor statistics
  bit mon_en = 1'b0;
  int mon_pairs, mon_done_cnt, mon_done_at;
  int cov[ASZ][N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pair_t ref_pair(input int s, input int k);
    pair_t p;
    int span;
    int lo;
    int hi;
    span = 1 << s;
    lo   = k % span;
    hi   = k / span;
    p.s  = s;
    p.k  = k;
    p.a  = hi * 2 * span + lo;
    p.b  = p.a + span;
    p.tw = lo * (1 << (ASZ - 1 - s));
    return p;
  endfunction

  task automatic next_stage();
    if (m_s == ASZ - 1) begin
      m_phase = P_DONE;
    end else begin
      m_s++;
      m_k = 0;
      m_phase = P_ISSUE;
    end
  endtask

  task automatic advance();
    case (m_phase)
      P_IDLE: if (bus.i_start && !rst) begin
        m_phase = P_ISSUE;
        m_s = 0;
        m_k = 0;
        m_start_cyc = cyc;
      end
      P_ISSUE: if (!bus.i_stall) begin
        m_k++;
        if (m_k == HALF) begin
          m_k = 0;
          if (PL == 0) next_stage();
          else begin
            m_phase = P_DRAIN;
            m_d = 0;
          end
        end
      end
      P_DRAIN: begin
        m_d++;
        if (m_d == PL) next_stage();
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic publish();
    pair_t p;
    e_busy  = (m_phase != P_IDLE);
    e_done  = (m_phase == P_DONE);
    e_idle  = (m_phase == P_IDLE);
    e_valid = (m_phase == P_ISSUE) && !bus.i_stall;
    e_held  = (m_phase == P_ISSUE) && bus.i_stall;
    p = ref_pair(m_s, m_k);
    if (e_valid) sb.push_back(p);
    if (e_held) begin
      e_ha = p.a;
      e_hb = p.b;
    end
    if (m_phase == P_DONE) begin
      m_dones++;
      if (m_dones == 1) m_done_cyc = cyc - m_start_cyc + 1;
    end
  endtask

  task automatic step(input int mode, input bit force_start);
    bit st;
    bit sl;
    @(posedge clk);
    cyc++;
    advance();
    #2;
    st = 1'b0;
    sl = 1'b0;
    if (force_start) st = 1'b1;
    else begin
      case (mode)
        1: if (m_phase == P_ISSUE && m_s == 1 && m_k == 6 && stalls_done < 3) begin
          sl = 1'b1;
          stalls_done++;
        end
        2: begin
          sl = ($urandom_range(0, 3) == 0);
          st = (m_phase != P_IDLE) && ($urandom_range(0, 4) == 0);
        end
        3: st = (m_dones < 2);
        4: begin
          sl = (m_phase == P_DRAIN);
          st = (m_phase == P_ISSUE) && (m_k == 3);
        end
        default: ;
      endcase
    end
    bus.i_start = st;
    bus.i_stall = sl;
    publish();
    if (mode == 1 && sl) begin
      #1;
      chk("stall_hold_A", bus.o_rdaddr_A, 12);
      chk("stall_hold_B", bus.o_rdaddr_B, 14);
      chk("stall_valid", bus.o_rd_valid, 0);
    end
  endtask

  task automatic clear_stats();
    mon_pairs    = 0;
    mon_done_cnt = 0;
    mon_done_at  = -1;
    m_dones      = 0;
    stalls_done  = 0;
    foreach (cov[i, j]) cov[i][j] = 0;
  endtask

  task automatic run(input int mode, input int runs, input int exp_done);
    int guard;
    int ok;
    clear_stats();
    step(mode, 1'b1);
    guard = 0;
    while (!(m_phase == P_IDLE && m_dones >= runs) && guard < 2000) begin
      step(mode, 1'b0);
      guard++;
    end
    chk("run_timeout", int'(guard < 2000), 1);
    step(0, 1'b0);
    step(0, 1'b0);
    chk("done_cycle", mon_done_at, (exp_done >= 0) ? exp_done : m_done_cyc);
    chk("done_count", mon_done_cnt, runs);
    chk("pair_count", mon_pairs, ASZ * HALF * runs);
    for (int s = 0; s < ASZ; s++) begin
      ok = 1;
      for (int a = 0; a < N; a++) if (cov[s][a] != runs) ok = 0;
      chk($sformatf("stage%0d_cover", s), ok, 1);
    end
    chk("sb_empty", sb.size(), 0);
  endtask

  // Monitor: compares every cycle against the model's expectations and the scoreboard.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", bus.o_busy, int'(e_busy));
        chk("done", bus.o_done, int'(e_done));
        chk("rd_valid", bus.o_rd_valid, int'(e_valid));
        if (bus.o_done === 1'b1) begin
          if (mon_done_cnt == 0) mon_done_at = cyc - m_start_cyc + 1;
          mon_done_cnt++;
        end
        if (e_idle)
          chk("idle_outputs", int'({bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_twiddle_idx, bus.o_stage}), 0);
        if (e_held) begin
          chk("held_A", bus.o_rdaddr_A, e_ha);
          chk("held_B", bus.o_rdaddr_B, e_hb);
        end
        if (bus.o_rd_valid === 1'b1) begin
          if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
          else begin
            p = sb.pop_front();
            chk("addr_A", bus.o_rdaddr_A, p.a);
            chk("addr_B", bus.o_rdaddr_B, p.b);
            chk("twiddle", bus.o_twiddle_idx, p.tw);
            chk("stage", bus.o_stage, p.s);
            chk("a_lt_b", int'(bus.o_rdaddr_A < bus.o_rdaddr_B), 1);
            if (p.s == 2 && p.k == 5)
              chk("dir_s2_k5", int'({bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_twiddle_idx}), int'({5'd9, 5'd13, 4'd4}));
            if (p.s == 4 && p.k == 15)
              chk("dir_s4_k15", int'({bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_twiddle_idx}), int'({5'd15, 5'd31, 4'd15}));
            if (p.s == 1 && p.k == 3)
              chk("dir_s1_k3", int'({bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_twiddle_idx}), int'({5'd5, 5'd7, 4'd8}));
            if (bus.o_stage < ASZ) begin
              cov[bus.o_stage][bus.o_rdaddr_A]++;
              cov[bus.o_stage][bus.o_rdaddr_B]++;
            end
            mon_pairs++;
          end
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int guard;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    cyc = 0;
    m_phase = P_IDLE;
    m_s = 0;
    m_k = 0;
    m_d = 0;
    m_start_cyc = 0;
    m_done_cyc = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_done", bus.o_done, 0);
    chk("reset_valid", bus.o_rd_valid, 0);
    chk("reset_addr", int'({bus.o_rdaddr_A, bus.o_rdaddr_B}), 0);
    chk("reset_twiddle_stage", int'({bus.o_twiddle_idx, bus.o_stage}), 0);
    rst = 1'b0;
    publish();
    mon_en = 1'b1;
    step(0, 1'b0);
    step(0, 1'b0);

    run(0, 1, 91);
    run(1, 1, 94);
    run(4, 1, 91);
    run(3, 2, 91);
    for (int r = 0; r < 3; r++) run(2, 1, -1);

    // Asynchronous reset in the middle of stage 3.
    clear_stats();
    step(0, 1'b1);
    guard = 0;
    while (!(m_phase == P_ISSUE && m_s == 3 && m_k == 5) && guard < 2000) begin
      step(0, 1'b0);
      guard++;
    end
    chk("abort_reach_timeout", int'(guard < 2000), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_busy", bus.o_busy, 0);
    chk("rst_async_done", bus.o_done, 0);
    chk("rst_async_valid", bus.o_rd_valid, 0);
    chk("rst_async_addr", int'({bus.o_rdaddr_A, bus.o_rdaddr_B}), 0);
    chk("rst_async_tw_stage", int'({bus.o_twiddle_idx, bus.o_stage}), 0);
    m_phase = P_IDLE;
    m_s = 0;
    m_k = 0;
    sb.delete();
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    publish();
    step(0, 1'b0);
    step(0, 1'b0);
    rst = 1'b0;
    step(0, 1'b0);
    chk("abort_no_done", mon_done_cnt, 0);
    run(0, 1, 91);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
